k_rpack_t1: RTL and testbench
=============================

K_RPACK_T1 -- requirements
Module: k_rpack_t1

Interface
REQ-001 SHALL have parameter data_size, default 8, width of one FIFO read word.
REQ-002 SHALL have parameter pack_num, default 4, FIFO words per packed output word (legal 2..8).
REQ-003 SHALL have parameter tmo_cycles, default 16, idle cycles before a partial-word flush (used only under K_RPACK_FLUSH_EN).
REQ-004 SHALL have ports; one clock; reset is synchronous and active-high:
- rclk  input  1  read-domain clock, all state on rising edge
- rrst  input  1  synchronous active-high reset
- rdata  input  data_size  FIFO read data, valid while rrdy=1
- rrdy  input  1  FIFO holds a word
- rget  output  1  pops the FIFO word this cycle
- odata  output  data_size*pack_num  packed word
- okeep  output  pack_num  per-lane valid mask of odata
- ovalid  output  1  odata/okeep valid
- ordy  input  1  consumer accepts when ovalid&&ordy

Function
REQ-005 SHALL drive rget combinationally = rrdy && accept, accept = !(cnt==pack_num-1 && ovalid && !ordy) && !flush_now.
REQ-006 SHALL sample rdata into lane cnt of the assembly register on each rclk edge with rget=1; lane 0 = first word (odata[data_size-1:0]).
REQ-007 SHALL keep lane counter cnt (0..pack_num-1), increment on rget, wrap to 0 after lane pack_num-1.
REQ-008 SHALL, on rget with cnt==pack_num-1, load the completed word (including the current rdata) into odata, set okeep all-ones, ovalid=1 next cycle; latency last pop -> ovalid = 1 cycle.
REQ-009 SHALL hold odata/okeep/ovalid stable while ovalid && !ordy.
REQ-010 SHALL clear ovalid after ovalid&&ordy unless a new word loads same edge; simultaneous accept+load keeps ovalid=1 with new data (full throughput, one packed word per pack_num cycles).
REQ-011 SHALL never pop while the output register is full and cannot drain (REQ-005); no word loss or duplication.
REQ-012 SHALL operate as states EMPTY (cnt=0, !ovalid), FILL (cnt>0), HOLD (ovalid && !ordy); transitions purely from cnt, ovalid, rget, ordy.
REQ-013 SHALL ignore rdata whenever rget=0.

Reset
REQ-014 SHALL, on rrst=1 at rclk edge, set cnt=0, ovalid=0, odata=0, okeep=0, idle timer=0; rget=0 while rrst=1.
REQ-015 SHALL discard any partial word on reset mid-fill; no flush emitted.

Configuration
REQ-016 SHALL, with K_RPACK_FLUSH_EN defined, count cycles with cnt>0 and rget=0; at tmo_cycles, assert flush_now, load the partial word into odata with okeep bit i=1 for lanes i<cnt, unfilled lanes zero, ovalid=1, cnt=0; flush waits while ovalid && !ordy; timer clears on any rget.
REQ-017 SHALL, without K_RPACK_FLUSH_EN, omit timer logic; flush_now=0; okeep is all-ones whenever ovalid=1; partial words wait indefinitely.

Structure
REQ-018 SHALL place lane-index width function (clog2) and state encodings in shared package k_fifo_pkg_t1.
REQ-019 SHALL be a single module; optional sub-module k_rpack_oreg_t1 for the output holding register.

Verification
REQ-020 Feed 8'h11,22,33,44 with rrdy=1, ordy=1 -> odata=32'h44332211, okeep=4'hF, ovalid one cycle after 4th rget.
REQ-021 rrdy=1 continuous, ordy=0 after first word -> exactly 3 further rget then rget=0; ordy=1 -> word 1 then word 2 in order, none lost.
REQ-022 8 words continuous, ordy=1 -> two packed words, ovalid not dropped between them when accept and load coincide.
REQ-023 Two words 8'hAA,BB then rrst pulse then 8'h01..04 -> single output 32'h04030201; no AA/BB visible.
REQ-024 K_RPACK_FLUSH_EN, tmo_cycles=16: 8'hAA,BB then rrdy=0 -> after 16 idle cycles odata=32'h0000BBAA, okeep=4'h3; without macro -> ovalid stays 0.

Source files
------------

// File: rtl/k_fifo_pkg_t1.sv
// k_fifo_pkg_t1 -- shared definitions for the FIFO read-side packer.
//
// Contents:
//   rpack_state_t : packer control states
//                   EMPTY - no partial lanes and no pending output word
//                   FILL  - at least one lane of the next word captured
//                   HOLD  - a packed word is pending, no partial lanes yet
//   lane_w()      : ceil(log2(n)) with a minimum of 1, used to size the
//                   lane counter and the idle timer
package k_fifo_pkg_t1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_HOLD  = 2'd2
  } rpack_state_t;

  // Smallest width that can index n distinct values (at least 1 bit).
  function automatic int lane_w(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/k_rpack_oreg_t1.sv
// k_rpack_oreg_t1 -- output holding register of the read-side packer.
//
// Ports:
//   rclk, rrst         : clock, synchronous active-high reset
//   load               : capture load_data/load_keep, raise ovalid
//   load_data/load_keep: packed word and its lane mask
//   ordy               : consumer handshake, drains the register
//   odata/okeep/ovalid : registered output word
//
// The top only asserts load when the register is empty or draining this
// cycle, so a load never overwrites a word the consumer has not taken.
module k_rpack_oreg_t1 #(
  parameter int data_size = 8,
  parameter int pack_num  = 4
) (
  input  logic                          rclk,
  input  logic                          rrst,
  input  logic                          load,
  input  logic [data_size*pack_num-1:0] load_data,
  input  logic [pack_num-1:0]           load_keep,
  input  logic                          ordy,
  output logic [data_size*pack_num-1:0] odata,
  output logic [pack_num-1:0]           okeep,
  output logic                          ovalid
);

  // A load wins over a drain on the same edge so that back-to-back words
  // keep ovalid high; otherwise an accepted word simply clears ovalid and
  // the data stays put while the consumer stalls.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      odata  <= '0;
      okeep  <= '0;
      ovalid <= 1'b0;
    end else if (load) begin
      odata  <= load_data;
      okeep  <= load_keep;
      ovalid <= 1'b1;
    end else if (ordy) begin
      ovalid <= 1'b0;
    end
  end

endmodule

// File: rtl/k_rpack_t1.sv
// k_rpack_t1 -- packs pack_num consecutive FIFO read words into one wide
// output word with a valid/ready handshake.
//
// Ports:
//   rclk, rrst : read-domain clock, synchronous active-high reset
//   rdata/rrdy : FIFO read data and "FIFO not empty"
//   rget       : pop strobe to the FIFO (combinational)
//   odata      : packed word, lane 0 = first word read (LSBs)
//   okeep      : per-lane valid mask of odata
//   ovalid/ordy: output handshake
//
// Optional feature: define K_RPACK_FLUSH_EN to flush a partial word after
// tmo_cycles idle cycles; without it a partial word waits indefinitely.
module k_rpack_t1 #(
  parameter int data_size  = 8,
  parameter int pack_num   = 4,
  parameter int tmo_cycles = 16
) (
  input  logic                          rclk,
  input  logic                          rrst,
  input  logic [data_size-1:0]          rdata,
  input  logic                          rrdy,
  output logic                          rget,
  output logic [data_size*pack_num-1:0] odata,
  output logic [pack_num-1:0]           okeep,
  output logic                          ovalid,
  input  logic                          ordy
);
  import k_fifo_pkg_t1::*;

  localparam int lw = lane_w(pack_num);
  localparam int ow = data_size * pack_num;
  localparam logic [lw-1:0] last = lw'(pack_num - 1);

  if (pack_num < 2 || pack_num > 8 || tmo_cycles < 1) begin : g_bad_param
    $error("k_rpack_t1: pack_num must be 2..8 and tmo_cycles >= 1");
  end

  rpack_state_t state, state_n;
  logic [lw-1:0] cnt;
  logic [(pack_num-1)*data_size-1:0] asm_q;
  logic [ow-1:0] full_word;
  logic [ow-1:0] load_data;
  logic [pack_num-1:0] load_keep;
  logic at_last, out_stall, accept, load, flush_now;

  // The last lane is only reachable in FILL; popping it while the output
  // register is full and stalled would lose a word, so that pop waits.
  assign at_last   = (state == ST_FILL) && (cnt == last);
  assign out_stall = ovalid && !ordy;
  assign accept    = !(at_last && out_stall) && !flush_now;
  assign rget      = rrdy && accept && !rrst;
  assign load      = (rget && at_last) || flush_now;

  // The final lane never needs storage: it is taken straight from rdata
  // on the edge that completes the word.
  always_comb begin
    full_word = {rdata, asm_q};
  end

  // Capture each popped word into its lane of the assembly register.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      asm_q <= '0;
    end else if (rget) begin
      for (int i = 0; i < pack_num - 1; i++) begin
        if (int'(cnt) == i) asm_q[i*data_size +: data_size] <= rdata;
      end
    end
  end

  // Lane counter: advances on every pop, wraps after the last lane, and
  // restarts after a flush of a partial word.
  always_ff @(posedge rclk) begin
    if (rrst || flush_now) begin
      cnt <= '0;
    end else if (rget) begin
      cnt <= at_last ? '0 : cnt + lw'(1);
    end
  end

`ifdef K_RPACK_FLUSH_EN
  localparam int tw = lane_w(tmo_cycles + 1);
  localparam logic [tw-1:0] tmo = tw'(tmo_cycles);

  logic [tw-1:0] timer;
  logic [ow-1:0] part_word;
  logic [pack_num-1:0] part_keep;

  // Once the timer has seen tmo_cycles idle cycles the partial word is
  // flushed, but only when the output register can take it.
  assign flush_now = (state == ST_FILL) && (timer == tmo) && !out_stall;

  // Idle timer: counts FILL cycles without a pop and saturates at the
  // timeout so a flush blocked by a stalled consumer is not forgotten.
  always_ff @(posedge rclk) begin
    if (rrst || rget || flush_now) begin
      timer <= '0;
    end else if (state == ST_FILL && timer != tmo) begin
      timer <= timer + tw'(1);
    end
  end

  // Partial word: only lanes below cnt are real, older lane contents are
  // masked to zero so stale data from a previous word never leaks out.
  always_comb begin
    part_word = '0;
    part_keep = '0;
    for (int i = 0; i < pack_num - 1; i++) begin
      if (i < int'(cnt)) begin
        part_word[i*data_size +: data_size] = asm_q[i*data_size +: data_size];
        part_keep[i] = 1'b1;
      end
    end
  end

  assign load_data = flush_now ? part_word : full_word;
  assign load_keep = flush_now ? part_keep : '1;
`else
  assign flush_now = 1'b0;
  assign load_data = full_word;
  assign load_keep = '1;
`endif

  // State register.
  always_ff @(posedge rclk) begin
    if (rrst) state <= ST_EMPTY;
    else      state <= state_n;
  end

  // Next state. HOLD is left either by the consumer taking the word
  // (back to EMPTY) or by the first pop of the next word (into FILL,
  // while the pending word may still be waiting on ordy).
  always_comb begin
    state_n = state;
    case (state)
      ST_EMPTY: if (rget) state_n = ST_FILL;
      ST_FILL:  if (load) state_n = ST_HOLD;
      ST_HOLD: begin
        if (rget)      state_n = ST_FILL;
        else if (ordy) state_n = ST_EMPTY;
      end
      default:  state_n = ST_EMPTY;
    endcase
  end

  k_rpack_oreg_t1 #(
    .data_size(data_size),
    .pack_num (pack_num)
  ) u_oreg (
    .rclk     (rclk),
    .rrst     (rrst),
    .load     (load),
    .load_data(load_data),
    .load_keep(load_keep),
    .ordy     (ordy),
    .odata    (odata),
    .okeep    (okeep),
    .ovalid   (ovalid)
  );

endmodule

// File: tb/tb_k_rpack_t1.sv
// tb_k_rpack_t1 -- directed self-checking bench for k_rpack_t1
// (data_size=8, pack_num=4, tmo_cycles=16). Inputs change 1 time unit
// after the rising edge; registered outputs are sampled there too, and
// rget is sampled one further unit later once the inputs have settled.
module tb_k_rpack_t1;

  localparam int data_size  = 8;
  localparam int pack_num   = 4;
  localparam int tmo_cycles = 16;

  logic        rclk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rrdy;
  logic        rget;
  logic [31:0] odata;
  logic [3:0]  okeep;
  logic        ovalid;
  logic        ordy;

  int errors = 0;
  int checks = 0;

  logic [31:0] outq[$];
  logic [3:0]  keepq[$];

  always #5 rclk = ~rclk;

  k_rpack_t1 #(
    .data_size (data_size),
    .pack_num  (pack_num),
    .tmo_cycles(tmo_cycles)
  ) dut (
    .rclk  (rclk),
    .rrst  (rrst),
    .rdata (rdata),
    .rrdy  (rrdy),
    .rget  (rget),
    .odata (odata),
    .okeep (okeep),
    .ovalid(ovalid),
    .ordy  (ordy)
  );

  // Record every word the consumer actually takes.
  always @(posedge rclk) begin
    if (ovalid && ordy && !rrst) begin
      outq.push_back(odata);
      keepq.push_back(okeep);
    end
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rrst = 1'b1; rrdy = 1'b1; ordy = 1'b0; rdata = 8'h55;
    tick();
    tick();
    #1;
    checks++;
    if (rget !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_rget got=%b want=0", rget);
    end
    checks++;
    if (ovalid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ovalid got=%b want=0", ovalid);
    end
    checks++;
    if (odata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_odata got=%h want=00000000", odata);
    end
    checks++;
    if (okeep !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_okeep got=%h want=0", okeep);
    end
    rrst = 1'b0; rrdy = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int v;
    ordy = 1'b1;
    outq.delete(); keepq.delete();
    for (int i = 0; i < 4; i++) begin
      v = 17 * (i + 1);
      rdata = v[7:0]; rrdy = 1'b1;
      #1;
      checks++;
      if (rget !== 1'b1 || ovalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_pop%0d rget=%b ovalid=%b want rget=1 ovalid=0", i, rget, ovalid);
      end
      tick();
    end
    rrdy = 1'b0; rdata = 8'hEE;
    checks++;
    if (ovalid !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_latency ovalid=%b want=1", ovalid);
    end
    checks++;
    if (odata !== 32'h44332211) begin
      errors++; $display("[TB] FAIL basic_odata got=%h want=44332211", odata);
    end
    checks++;
    if (okeep !== 4'hF) begin
      errors++; $display("[TB] FAIL basic_okeep got=%h want=f", okeep);
    end
    tick();
    checks++;
    if (ovalid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_drain ovalid=%b want=0", ovalid);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int stall_pops;
    idx = 0; stall_pops = 0;
    ordy = 1'b1;
    outq.delete(); keepq.delete();
    for (int i = 0; i < 4; i++) begin
      rdata = 8'(idx + 1); rrdy = 1'b1;
      #1;
      if (rget) idx++;
      tick();
    end
    ordy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rdata = 8'(idx + 1); rrdy = 1'b1;
      #1;
      if (rget) begin idx++; stall_pops++; end
      tick();
    end
    rdata = 8'(idx + 1); rrdy = 1'b1;
    #1;
    checks++;
    if (stall_pops != 3) begin
      errors++; $display("[TB] FAIL bp_further_pops got=%0d want=3", stall_pops);
    end
    checks++;
    if (rget !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_stall_rget got=%b want=0", rget);
    end
    checks++;
    if (ovalid !== 1'b1 || odata !== 32'h04030201) begin
      errors++; $display("[TB] FAIL bp_hold ovalid=%b odata=%h want 1/04030201", ovalid, odata);
    end
    ordy = 1'b1;
    #1;
    checks++;
    if (rget !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_resume_rget got=%b want=1", rget);
    end
    if (rget) idx++;
    tick();
    rrdy = 1'b0;
    checks++;
    if (ovalid !== 1'b1 || odata !== 32'h08070605) begin
      errors++; $display("[TB] FAIL bp_coincide ovalid=%b odata=%h want 1/08070605", ovalid, odata);
    end
    tick();
    tick();
    checks++;
    if (outq.size() != 2) begin
      errors++; $display("[TB] FAIL bp_count got=%0d want=2", outq.size());
    end else if (outq[0] !== 32'h04030201 || outq[1] !== 32'h08070605) begin
      errors++; $display("[TB] FAIL bp_order got=%h,%h want=04030201,08070605", outq[0], outq[1]);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    int pops_seen;
    hi = 0; pops_seen = 0;
    ordy = 1'b1;
    outq.delete(); keepq.delete();
    for (int i = 0; i < 8; i++) begin
      rdata = 8'(8'h10 + i); rrdy = 1'b1;
      #1;
      if (rget) pops_seen++;
      tick();
      if (ovalid) hi++;
    end
    rrdy = 1'b0;
    checks++;
    if (pops_seen != 8) begin
      errors++; $display("[TB] FAIL b2b_throughput pops=%0d want=8", pops_seen);
    end
    checks++;
    if (hi != 2 || ovalid !== 1'b1 || odata !== 32'h17161514) begin
      errors++;
      $display("[TB] FAIL b2b_ovalid hi=%0d ovalid=%b odata=%h want 2/1/17161514", hi, ovalid, odata);
    end
    tick();
    tick();
    checks++;
    if (outq.size() != 2) begin
      errors++; $display("[TB] FAIL b2b_count got=%0d want=2", outq.size());
    end else if (outq[0] !== 32'h13121110 || outq[1] !== 32'h17161514) begin
      errors++; $display("[TB] FAIL b2b_words got=%h,%h want=13121110,17161514", outq[0], outq[1]);
    end
  endtask

  task automatic test_reset_midfill();
    ordy = 1'b1;
    outq.delete(); keepq.delete();
    rdata = 8'hAA; rrdy = 1'b1;
    tick();
    rdata = 8'hBB;
    tick();
    rrdy = 1'b0; rrst = 1'b1;
    tick();
    rrst = 1'b0;
    checks++;
    if (ovalid !== 1'b0 || okeep !== 4'h0) begin
      errors++; $display("[TB] FAIL midfill_reset ovalid=%b okeep=%h want 0/0", ovalid, okeep);
    end
    for (int i = 0; i < 4; i++) begin
      rdata = 8'(i + 1); rrdy = 1'b1;
      tick();
    end
    rrdy = 1'b0;
    checks++;
    if (ovalid !== 1'b1 || odata !== 32'h04030201 || okeep !== 4'hF) begin
      errors++;
      $display("[TB] FAIL midfill_word ovalid=%b odata=%h okeep=%h want 1/04030201/f", ovalid, odata, okeep);
    end
    tick();
    tick();
    checks++;
    if (outq.size() != 1) begin
      errors++; $display("[TB] FAIL midfill_count got=%0d want=1", outq.size());
    end else if (outq[0] !== 32'h04030201) begin
      errors++; $display("[TB] FAIL midfill_out got=%h want=04030201", outq[0]);
    end
  endtask

  task automatic test_flush();
    int k_hit;
    logic [31:0] d_hit;
    logic [3:0]  m_hit;
    k_hit = 0; d_hit = '0; m_hit = '0;
    ordy = 1'b1;
    outq.delete(); keepq.delete();
    rdata = 8'hAA; rrdy = 1'b1;
    tick();
    rdata = 8'hBB;
    tick();
    rrdy = 1'b0; rdata = 8'h5A;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ovalid && k_hit == 0) begin
        k_hit = k; d_hit = odata; m_hit = okeep;
      end
    end
`ifdef K_RPACK_FLUSH_EN
    // 16 idle cycles counted, the flush cycle itself, then ovalid.
    checks++;
    if (k_hit != 17) begin
      errors++; $display("[TB] FAIL flush_timing edge=%0d want=17", k_hit);
    end
    checks++;
    if (d_hit !== 32'h0000BBAA) begin
      errors++; $display("[TB] FAIL flush_odata got=%h want=0000bbaa", d_hit);
    end
    checks++;
    if (m_hit !== 4'h3) begin
      errors++; $display("[TB] FAIL flush_okeep got=%h want=3", m_hit);
    end
`else
    checks++;
    if (k_hit != 0 || outq.size() != 0) begin
      errors++;
      $display("[TB] FAIL noflush_ovalid edge=%0d words=%0d want 0/0", k_hit, outq.size());
    end
`endif
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    tick();
  endtask

  initial begin
    rrst = 1'b1; rrdy = 1'b0; ordy = 1'b0; rdata = '0;
    $display("[TB] start");
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_midfill();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
